// File: rtl/mem_xfer_ctrl.sv
// Sequencer that loads DEPTH words into bank A and then copies bank A into bank B.
// Optional macro CHECKSUM_EN adds a Checksum output: the XOR of the words written into bank B.
module mem_xfer_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 8
) (
    input  logic          clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InValid,
    input  logic [DW-1:0] InData,
    output logic          InReady,
    output logic          IncA,
    output logic          WEA,
    output logic [DW-1:0] DataA,
    input  logic [DW-1:0] RdA,
    output logic          IncB,
    output logic          WEB,
    output logic [DW-1:0] DataB,
    output logic          MemRst,
    output logic          Busy,
    output logic          Done,
`ifdef CHECKSUM_EN
    output logic [AW:0]   Count,
    output logic [DW-1:0] Checksum
`else
    output logic [AW:0]   Count
`endif
);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, XFER, FIN} state_t;

    localparam logic [AW:0] DepthW   = DEPTH[AW:0];
    localparam logic [AW:0] LastWord = DepthW - 1'b1;

    state_t      state;
    logic [AW:0] rdCnt;
    logic        rdVld_p0;
    logic        rdVld_p1;

    assign InReady = (state == LOAD);
    assign Busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state    <= IDLE;
            rdCnt    <= '0;
            rdVld_p0 <= 1'b0;
            rdVld_p1 <= 1'b0;
            IncA     <= 1'b0;
            WEA      <= 1'b0;
            IncB     <= 1'b0;
            WEB      <= 1'b0;
            DataA    <= '0;
            DataB    <= '0;
            Done     <= 1'b0;
            Count    <= '0;
            MemRst   <= 1'b1;
`ifdef CHECKSUM_EN
            Checksum <= '0;
`endif
        end else begin
            IncA     <= 1'b0;
            WEA      <= 1'b0;
            IncB     <= 1'b0;
            WEB      <= 1'b0;
            Done     <= 1'b0;
            rdVld_p0 <= 1'b0;
            // stage p0 -> p1: RdA holds the word addressed by the read command
            rdVld_p1 <= rdVld_p0;
            // stage p1 -> bank B write command
            if (rdVld_p1) begin
                DataB <= RdA;
                WEB   <= 1'b1;
                IncB  <= 1'b1;
                Count <= Count + 1'b1;
`ifdef CHECKSUM_EN
                Checksum <= Checksum ^ RdA;
`endif
            end
            case (state)
                IDLE: begin
                    MemRst <= Start;
                    if (Start) begin
                        state <= CLR;
                        Count <= '0;
`ifdef CHECKSUM_EN
                        Checksum <= '0;
`endif
                    end
                end
                CLR: begin
                    MemRst <= 1'b0;
                    Count  <= '0;
                    state  <= LOAD;
`ifdef CHECKSUM_EN
                    Checksum <= '0;
`endif
                end
                LOAD: begin
                    if (InValid) begin
                        DataA <= InData;
                        WEA   <= 1'b1;
                        IncA  <= 1'b1;
                        if (Count == LastWord) begin
                            state <= XFER;
                            Count <= '0;
                            rdCnt <= '0;
                        end else begin
                            Count <= Count + 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (rdCnt < DepthW) begin
                        IncA     <= 1'b1;
                        rdCnt    <= rdCnt + 1'b1;
                        rdVld_p0 <= 1'b1;
                    end
                    // the edge issuing the final B write also moves to FIN
                    if (rdVld_p1 && Count == LastWord) begin
                        state <= FIN;
                        Done  <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Randomized scoreboard bench for mem_xfer_ctrl with behavioural models of banks A and B.
module tb_mem_xfer_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          Reset, Start, InValid;
    logic [DW-1:0] InData;
    logic          InReady, IncA, WEA, IncB, WEB, MemRst, Busy, Done;
    logic [DW-1:0] DataA, DataB, RdA;
    logic [AW:0]   Count;
`ifdef CHECKSUM_EN
    logic [DW-1:0] Checksum;
`endif

    mem_xfer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock(clock), .Reset(Reset), .Start(Start), .InValid(InValid), .InData(InData),
        .InReady(InReady), .IncA(IncA), .WEA(WEA), .DataA(DataA), .RdA(RdA),
        .IncB(IncB), .WEB(WEB), .DataB(DataB), .MemRst(MemRst), .Busy(Busy), .Done(Done),
`ifdef CHECKSUM_EN
        .Count(Count), .Checksum(Checksum)
`else
        .Count(Count)
`endif
    );

    // Bank models: auto-increment pointer, registered read, pointer cleared by MemRst
    logic [DW-1:0] memA [DEPTH];
    logic [DW-1:0] memB [DEPTH];
    logic [AW-1:0] ptrA, ptrB;
    always @(posedge clock) begin
        if (MemRst) begin
            ptrA <= '0;
            ptrB <= '0;
        end else begin
            if (WEA) memA[ptrA] <= DataA;
            if (IncA) ptrA <= ptrA + 1'b1;
            if (WEB) memB[ptrB] <= DataB;
            if (IncB) ptrB <= ptrB + 1'b1;
        end
        RdA <= memA[ptrA];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [DW-1:0] aQ[$];
    logic [DW-1:0] bQ[$];
    int            doneQ[$];
    logic [DW-1:0] expB [DEPTH];
    logic [DW-1:0] expCs;
    logic [DW-1:0] jobData [DEPTH];
    int            jobGen = 0;
    int            doneSeen = 0;
    int            startCyc = 0;

    // Monitor: pops expectations whenever the DUT issues a bank command or Done
    int seenGen = 0, aIdx = 0, bIdx = 0;
    bit bankChk = 1'b0;
    always @(negedge clock) begin
        if (seenGen != jobGen) begin
            seenGen = jobGen;
            aIdx = 0;
            bIdx = 0;
        end
        if (bankChk) begin
            bankChk = 1'b0;
            for (int i = 0; i < DEPTH; i++) check("bank_b_word", memB[i], expB[i]);
        end
        if (Reset) begin
            if (WEA) begin
                if (aQ.size() == 0) check("unexpected_wea", 1, 0);
                else begin
                    check("data_a", DataA, aQ.pop_front());
                    check("ptr_a", ptrA, aIdx);
                    check("inc_a_with_wea", IncA, 1);
                end
                aIdx++;
            end
            if (WEB) begin
                if (bQ.size() == 0) check("unexpected_web", 1, 0);
                else begin
                    check("data_b", DataB, bQ.pop_front());
                    check("ptr_b", ptrB, bIdx);
                    check("inc_b_with_web", IncB, 1);
                end
                bIdx++;
            end
            if (Done) begin
                if (doneQ.size() == 0) check("unexpected_done", 1, 0);
                else check("done_cycle", cyc, doneQ.pop_front());
                check("count_at_done", Count, DEPTH);
`ifdef CHECKSUM_EN
                check("checksum_at_done", Checksum, expCs);
`endif
                bankChk = 1'b1;
                doneSeen++;
            end
        end
    end

    task automatic startJob(input bit hold);
        Start = 1'b1;
        @(posedge clock); #1;
        startCyc = cyc;
        jobGen++;
        expCs = '0;
        if (!hold) Start = 1'b0;
        check("clr_inready", InReady, 0);
        check("clr_memrst", MemRst, 1);
        check("clr_busy", Busy, 1);
        check("clr_count", Count, 0);
`ifdef CHECKSUM_EN
        check("clr_checksum", Checksum, 0);
`endif
    endtask

    // mode 0: back-to-back, 1: alternate 1,0,1,0, 2: random valid
    task automatic loadWords(input int mode, input int nWords);
        int acc = 0;
        int nCyc = 0;
        bit ph = 1'b1;
        InValid = 1'b0;
        @(posedge clock); #1;
        while (acc < nWords && nCyc < 200) begin
            case (mode)
                0:       InValid = 1'b1;
                1:       InValid = ph;
                default: InValid = 1'($urandom_range(0, 1));
            endcase
            ph = !ph;
            InData = InValid ? jobData[acc] : DW'($urandom);
            check("load_inready", InReady, 1);
            check("load_busy", Busy, 1);
            check("load_count", Count, acc);
            @(posedge clock); #1;
            nCyc++;
            if (InValid) begin
                aQ.push_back(InData);
                bQ.push_back(InData);
                expB[acc] = InData;
                expCs = expCs ^ InData;
                acc++;
            end
        end
        if (nWords == DEPTH) begin
            doneQ.push_back(startCyc + 1 + nCyc + DEPTH + 2);
            InValid = 1'($urandom_range(0, 1));
            InData = DW'($urandom);
            check("xfer_inready", InReady, 0);
            @(posedge clock); #1;
            InValid = 1'b0;
        end
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (doneSeen < target && n < 60) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("done_seen", doneSeen, target);
    endtask

    task automatic fillRandom();
        for (int i = 0; i < DEPTH; i++) jobData[i] = DW'($urandom);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int dn = 0;
    initial begin
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0; InData = '0;
        expCs = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_memrst", MemRst, 1);
        check("rst_busy", Busy, 0);
        check("rst_count", Count, 0);
        check("rst_wea", WEA, 0);
        check("rst_done", Done, 0);
        check("rst_inready", InReady, 0);
        Reset = 1'b1;
        @(posedge clock); #1;
        check("memrst_release", MemRst, 0);

        for (int i = 0; i < DEPTH; i++) jobData[i] = DW'(8'h11 * (i + 1));
        startJob(0); loadWords(0, DEPTH); waitDone(++dn);

        fillRandom(); startJob(0); loadWords(1, DEPTH); waitDone(++dn);
        fillRandom(); startJob(0); loadWords(2, DEPTH); waitDone(++dn);

        // abandon a job mid-load
        fillRandom(); startJob(0); loadWords(0, 4);
        Reset = 1'b0; InValid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("midrst_memrst", MemRst, 1);
        check("midrst_busy", Busy, 0);
        check("midrst_count", Count, 0);
        check("midrst_wea", WEA, 0);
        aQ.delete(); bQ.delete();
        Reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_release_memrst", MemRst, 0);
        check("midrst_release_busy", Busy, 0);
        fillRandom(); startJob(0); loadWords(0, DEPTH); waitDone(++dn);

        // Start held through a whole job: restart only from IDLE after Done
        fillRandom(); startJob(1); loadWords(0, DEPTH); waitDone(++dn);
        check("held_start_idle", Busy, 0);
        fillRandom(); startJob(0); loadWords(2, DEPTH); waitDone(++dn);

        for (int i = 0; i < DEPTH; i++) jobData[i] = DW'(8'hFF - i);
        startJob(0); loadWords(0, DEPTH); waitDone(++dn);
        for (int i = 0; i < DEPTH; i++) jobData[i] = DW'(i);
        startJob(0); loadWords(1, DEPTH); waitDone(++dn);

        for (int i = 0; i < DEPTH; i++) jobData[i] = DW'(1 << i);
        startJob(0); loadWords(0, DEPTH); waitDone(++dn);
`ifdef CHECKSUM_EN
        check("checksum_ff", Checksum, 8'hFF);
`endif
        fillRandom(); startJob(0); loadWords(2, DEPTH); waitDone(++dn);

        repeat (3) @(posedge clock);
        #1;
        check("a_queue_empty", aQ.size(), 0);
        check("b_queue_empty", bQ.size(), 0);
        check("done_queue_empty", doneQ.size(), 0);
        check("final_busy", Busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
